// File: rtl/det_session_ctrl.sv
// rtl/det_session_ctrl.sv - session controller feeding a 1011 overlapping Mealy detector
// Optional first-hit position capture enabled by macro DET_SESSION_FIRST_POS_EN.
module det_session_ctrl #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 5,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic              det_clr_n_o,
  output logic              det_seq_o,
  input  logic              det_hit_i,
  output logic [LEN_W-1:0]  first_pos_o,
  output logic              first_vld_o
);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_SHIFT, S_DONE} state_t;

  localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(DATA_W);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [LEN_W-1:0]  r_bitcnt, w_bitcnt_nxt;
  logic [LEN_W-1:0]  w_len_clamp;
  logic [CNT_W-1:0]  r_hit_cnt, w_hit_cnt_nxt;
  logic              r_clr_n, w_clr_n_nxt;
  logic              r_seq, w_seq_nxt;

  assign w_len_clamp = (len_i > LP_MAX_LEN) ? LP_MAX_LEN : len_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_len     <= '0;
      r_bitcnt  <= '0;
      r_hit_cnt <= '0;
      r_clr_n   <= 1'b1;
      r_seq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_len     <= w_len_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_hit_cnt <= w_hit_cnt_nxt;
      r_clr_n   <= w_clr_n_nxt;
      r_seq     <= w_seq_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_len_nxt     = r_len;
    w_bitcnt_nxt  = r_bitcnt;
    w_hit_cnt_nxt = r_hit_cnt;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt   = S_CLR;
          w_shift_nxt   = data_i;
          w_len_nxt     = w_len_clamp;
          w_bitcnt_nxt  = '0;
          w_hit_cnt_nxt = '0;
        end
      end
      S_CLR: begin
        if (abort_i)             w_state_nxt = S_IDLE;
        else if (r_len == '0)    w_state_nxt = S_DONE;
        else                     w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_shift_nxt  = r_shift << 1;
          w_bitcnt_nxt = r_bitcnt + LEN_W'(1);
          if (det_hit_i && (r_hit_cnt != LP_CNT_MAX))
            w_hit_cnt_nxt = r_hit_cnt + CNT_W'(1);
          if (w_bitcnt_nxt == r_len)
            w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Detector drive is computed from the next state so both pins leave a flop.
    w_clr_n_nxt = (w_state_nxt != S_CLR);
    w_seq_nxt   = (w_state_nxt == S_SHIFT) ? w_shift_nxt[DATA_W-1] : 1'b0;
  end

  assign ready_o     = (r_state == S_IDLE);
  assign busy_o      = (r_state == S_CLR) || (r_state == S_SHIFT);
  assign done_o      = (r_state == S_DONE);
  assign hit_cnt_o   = r_hit_cnt;
  assign det_clr_n_o = r_clr_n;
  assign det_seq_o   = r_seq;

`ifdef DET_SESSION_FIRST_POS_EN
  logic [LEN_W-1:0] r_first_pos;
  logic             r_first_vld;
  logic             w_hit_take;

  assign w_hit_take = (r_state == S_SHIFT) && !abort_i && det_hit_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_pos <= '0;
      r_first_vld <= 1'b0;
    end else if ((r_state == S_IDLE) && start_i) begin
      r_first_pos <= '0;
      r_first_vld <= 1'b0;
    end else if (w_hit_take && !r_first_vld) begin
      r_first_pos <= r_bitcnt;
      r_first_vld <= 1'b1;
    end
  end

  assign first_pos_o = r_first_pos;
  assign first_vld_o = r_first_vld;
`else
  assign first_pos_o = '0;
  assign first_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_det_session_ctrl.sv
// tb/tb_det_session_ctrl.sv - directed scoreboard bench for det_session_ctrl
module tb_det_session_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [4:0]  len_i = '0;
  logic        abort_i = 1'b0;
  logic        ready_o, busy_o, done_o, det_clr_n_o, det_seq_o, det_hit_i, first_vld_o;
  logic [4:0]  hit_cnt_o, first_pos_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int hits;
    int lat;
    int fpos;
    int fvld;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  det_session_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .data_i(data_i), .len_i(len_i),
    .abort_i(abort_i), .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .hit_cnt_o(hit_cnt_o), .det_clr_n_o(det_clr_n_o), .det_seq_o(det_seq_o),
    .det_hit_i(det_hit_i), .first_pos_o(first_pos_o), .first_vld_o(first_vld_o)
  );

  // External 1011 overlapping Mealy detector; state: 0 none, 1 "1", 2 "10", 3 "101".
  logic [1:0] r_ds;
  logic       w_det_rst_n;
  assign w_det_rst_n = det_clr_n_o & rst_n;
  assign det_hit_i   = (r_ds == 2'd3) && det_seq_o;

  always @(posedge clk or negedge w_det_rst_n) begin
    if (!w_det_rst_n) r_ds <= 2'd0;
    else case (r_ds)
      2'd0: r_ds <= det_seq_o ? 2'd1 : 2'd0;
      2'd1: r_ds <= det_seq_o ? 2'd1 : 2'd2;
      2'd2: r_ds <= det_seq_o ? 2'd3 : 2'd0;
      default: r_ds <= det_seq_o ? 2'd1 : 2'd2;
    endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [15:0] d, input int len, input int stop);
    exp_t r;
    int n;
    int lim;
    logic [3:0] w;
    n = (len > 16) ? 16 : len;
    lim = (stop >= 0 && stop < n) ? stop : n;
    w = 4'b0000;
    r.hits = 0; r.fpos = 0; r.fvld = 0; r.lat = n + 2;
    for (int i = 0; i < lim; i++) begin
      w = {w[2:0], d[15-i]};
      if (i >= 3 && w == 4'b1011) begin
        r.hits++;
        if (r.fvld == 0) begin r.fvld = 1; r.fpos = i; end
      end
    end
`ifndef DET_SESSION_FIRST_POS_EN
    r.fpos = 0; r.fvld = 0;
`endif
    return r;
  endfunction

  task automatic check_pos(input string tag, input exp_t e);
    chk({tag, "_first_pos"}, int'(first_pos_o), e.fpos);
    chk({tag, "_first_vld"}, int'(first_vld_o), e.fvld);
  endtask

  task automatic do_session(input string tag, input logic [15:0] d, input int len,
                            input int abort_at, input bit hold);
    exp_t e, got_e;
    int n, nb, cyc;
    logic [31:0] got;
    bit finished;
    n = (len > 16) ? 16 : len;
    e = ref_model(d, len, abort_at);
    @(negedge clk);
    start_i = 1'b1; data_i = d; len_i = 5'(len);
    if (abort_at < 0) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start_i = hold;
    chk({tag, "_clr_n"}, int'(det_clr_n_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 1);
    chk({tag, "_cnt_clr"}, int'(hit_cnt_o), 0);
    got = '0; nb = 0; finished = 1'b0;
    for (cyc = 2; cyc < 40 && !finished; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      abort_i = (abort_at >= 0) && (cyc == 2 + abort_at);
      if (busy_o && det_clr_n_o) begin
        got = {got[30:0], det_seq_o};
        nb++;
      end
      if (done_o) begin
        finished = 1'b1;
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
        else begin
          got_e = sb.pop_front();
          chk({tag, "_latency"}, cyc, got_e.lat);
          chk({tag, "_hits"}, int'(hit_cnt_o), got_e.hits);
          check_pos(tag, got_e);
          chk({tag, "_nbits"}, nb, n);
          chk({tag, "_seq"}, int'(got), int'(32'(d) >> (16 - n)));
        end
      end else if (abort_at >= 0 && cyc == 3 + abort_at) begin
        finished = 1'b1;
        chk({tag, "_ab_ready"}, int'(ready_o), 1);
        chk({tag, "_ab_hits"}, int'(hit_cnt_o), e.hits);
        chk({tag, "_ab_clr_n"}, int'(det_clr_n_o), 1);
        chk({tag, "_ab_seq"}, int'(det_seq_o), 0);
        check_pos({tag, "_ab"}, e);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ab_no_done"}, int'(done_o), 0);
      end
    end
    if (!finished) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int cyc;
    bit seen;
    #12;
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_cnt", int'(hit_cnt_o), 0);
    chk("rst_clr_n", int'(det_clr_n_o), 1);
    chk("rst_seq", int'(det_seq_o), 0);
    chk("rst_fpos", int'(first_pos_o), 0);
    chk("rst_fvld", int'(first_vld_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_session("b600", 16'hB600, 7, -1, 1'b0);
    do_session("ffff", 16'hFFFF, 16, -1, 1'b0);
    do_session("len0", 16'hB6DB, 0, -1, 1'b0);
    do_session("len20", 16'hB6DB, 20, -1, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_hold_cnt", int'(hit_cnt_o), 5);
    do_session("abort", 16'hB6DB, 16, 7, 1'b0);
    do_session("rnd", 16'(($urandom & 32'hFFFF) | 32'h2000), 13, -1, 1'b0);

    // Start held high: the second session must only begin from IDLE.
    do_session("hold", 16'hB600, 7, -1, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("hold_idle_ready", int'(ready_o), 1);
    chk("hold_idle_cnt", int'(hit_cnt_o), 2);
    @(posedge clk); @(negedge clk);
    start_i = 1'b0;
    chk("hold_clr_n", int'(det_clr_n_o), 0);
    chk("hold_cnt_clr", int'(hit_cnt_o), 0);
    @(posedge clk); @(negedge clk);
    chk("hold_clr_one", int'(det_clr_n_o), 1);
    e = ref_model(16'hB600, 7, -1);
    seen = 1'b0;
    for (cyc = 3; cyc < 40 && !seen; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        chk("hold2_latency", cyc, e.lat);
        chk("hold2_hits", int'(hit_cnt_o), e.hits);
      end
    end
    if (!seen) chk("hold2_timeout", 0, 1);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    start_i = 1'b1; data_i = 16'hB6DB; len_i = 5'd16;
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", int'(ready_o), 1);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_cnt", int'(hit_cnt_o), 0);
    chk("arst_clr_n", int'(det_clr_n_o), 1);
    chk("arst_seq", int'(det_seq_o), 0);
    chk("arst_fvld", int'(first_vld_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("arst_rel_ready", int'(ready_o), 1);
    chk("arst_rel_done", int'(done_o), 0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/det_session_ctrl.md
Name: det_session_ctrl

Overview:
- Session controller that drives an external 1011 overlapping Mealy sequence detector.
- Accepts a parallel word and a bit length from a host, then clears the detector and serialises the word into it MSB-first, one bit per clock.
- Counts detector hits and reports completion with the hit count.
- Sits between the host register interface and the detector instance.

Parameters:
- DATA_W, 16: width of the parallel data word and maximum session length in bits.
- LEN_W, 5: width of len_i; must hold DATA_W.
- CNT_W, 5: width of the hit counter; saturates at all-ones.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start_i  input  1  session request; accepted only when ready_o=1
- data_i  input  DATA_W  word to serialise; data_i[DATA_W-1] is sent first
- len_i  input  LEN_W  number of bits to send, 0..DATA_W; values >DATA_W are clamped to DATA_W
- abort_i  input  1  terminate the current session
- ready_o  output  1  high in IDLE
- busy_o  output  1  high in CLR and SHIFT
- done_o  output  1  one-cycle pulse at normal session end
- hit_cnt_o  output  CNT_W  detector hits in the last or current session
- det_clr_n_o  output  1  registered clear to the detector's active-low reset
- det_seq_o  output  1  registered serial bit to the detector's i_seq
- det_hit_i  input  1  detector o_det (Mealy, combinational from det_seq_o)
- first_pos_o  output  LEN_W  see Optional Feature
- first_vld_o  output  1  see Optional Feature

Behaviour:
- Reset values: state=IDLE, ready_o=1, busy_o=0, done_o=0, hit_cnt_o=0, det_clr_n_o=1, det_seq_o=0, first_pos_o=0, first_vld_o=0. Shift register and bit counter are cleared.
- FSM states: IDLE, CLR, SHIFT, DONE.
- IDLE:
  - start_i=1 at edge T latches data_i, latches clamped len_i, clears hit_cnt_o, and moves to CLR.
  - start_i while busy is ignored.
- CLR (one cycle):
  - det_clr_n_o=0 and det_seq_o=0.
  - len=0 goes to DONE (zero hits); otherwise goes to SHIFT.
- SHIFT:
  - Each cycle det_seq_o carries the current MSB of the shift register.
  - det_hit_i is sampled at the end of that cycle; if 1, hit_cnt_o increments, saturating at 2^CNT_W-1.
  - The shift register shifts left and the bit counter increments.
  - After exactly len cycles, go to DONE.
  - det_clr_n_o=1 throughout.
- DONE (one cycle): done_o=1, det_seq_o=0, next state IDLE.
- Latency: start accepted at edge T gives done_o high in cycle T+len+2.
- hit_cnt_o holds its value in IDLE until the next accepted start.
- abort_i has priority over every other transition in CLR and SHIFT:
  - Next state is IDLE and no done_o pulse is produced.
  - hit_cnt_o keeps its partial count.
  - det_clr_n_o returns to 1 and det_seq_o goes to 0.
  - abort_i in IDLE or DONE is ignored; DONE still pulses.
- Asynchronous reset mid-session returns every output to its reset value immediately.
- The detector is always cleared before the first bit, so no state carries over from a previous session.

Optional Feature:
- Macro: DET_SESSION_FIRST_POS_EN.
- With the macro defined:
  - On the first hit of a session, first_pos_o latches the 0-based index of the bit that completed the match, and first_vld_o is set to 1.
  - Both are cleared on start acceptance and held otherwise, including after abort.
- Without the macro: first_pos_o=0 and first_vld_o=0 constantly, and no position logic is synthesised.

Test Plan:
- Reset asserted mid-SHIFT -> all outputs at reset values within the same cycle; ready_o=1 after release.
- data_i=16'hB600, len_i=7 (bits 1011011) -> det_seq_o sequence 1,0,1,1,0,1,1; done_o at T+9; hit_cnt_o=2; with macro first_pos_o=3, first_vld_o=1.
- data_i=16'hFFFF, len_i=16 -> hit_cnt_o=0, done_o at T+18; with macro first_vld_o=0.
- len_i=0 -> CLR then DONE; done_o at T+2, hit_cnt_o=0. len_i=20 -> treated as 16, done_o at T+18.
- data_i=16'hB6DB (1011011011011011), len_i=16 -> hit_cnt_o=5. Same word with abort_i pulsed in the 8th SHIFT cycle -> no done_o, hit_cnt_o=2, IDLE next cycle.
- start_i held high during a session -> ignored until ready_o=1; second session starts with det_clr_n_o=0 for one cycle and hit_cnt_o reset to 0.
